// File: rtl/pwm_seq_ctrl_if.sv
// Configuration bus of the PWM sequencer: one write port into the 4-entry step table.
interface pwm_seq_ctrl_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_period;
    logic [15:0] cfg_dc;
    logic [7:0]  cfg_reps;

    modport master (output cfg_we, cfg_addr, cfg_period, cfg_dc, cfg_reps);
    modport slave  (input  cfg_we, cfg_addr, cfg_period, cfg_dc, cfg_reps);
endinterface

// File: rtl/pwm_seq_ctrl.sv
// PWM step sequencer: walks a 4-entry {period, duty, repeats} table and feeds the
// selected entry to the PWM datapath, advancing on each completed PWM period.
module pwm_seq_ctrl (
    input  logic          chosen_clk,
    input  logic          rst,
    pwm_seq_ctrl_if.slave cfg,
    input  logic [1:0]    seq_len,
    input  logic          loop,
    input  logic          start,
    input  logic          abort,
    input  logic          period_tick,
    output logic [15:0]   period_reg,
    output logic [15:0]   DC_reg,
    output logic          pwm_en,
    output logic          busy,
    output logic [1:0]    step,
    output logic          done,
    output logic          cfg_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] tbl_period_r [4];
    logic [15:0] tbl_dc_r     [4];
    logic [7:0]  tbl_reps_r   [4];
    logic [7:0]  rep_cnt_r, rep_cnt_s;
    logic [1:0]  len_r, len_s;
    logic        loop_r, loop_s;
    logic [15:0] period_s, dc_s;
    logic        pwm_en_s, busy_s, done_s, cfg_err_s;
    logic [1:0]  step_s, adv_step_s;
    logic        tbl_we_s;
    logic [15:0] entry0_period_s;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s    = state_r;
        period_s   = period_reg;
        dc_s       = DC_reg;
        pwm_en_s   = pwm_en;
        busy_s     = busy;
        step_s     = step;
        done_s     = 1'b0;
        cfg_err_s  = 1'b0;
        rep_cnt_s  = rep_cnt_r;
        len_s      = len_r;
        loop_s     = loop_r;
        tbl_we_s   = 1'b0;
        adv_step_s = (step == len_r) ? 2'd0 : step + 2'd1;
        // A write landing in the same cycle as start must count for the start check.
        entry0_period_s = (cfg.cfg_we && (cfg.cfg_addr == 2'd0)) ? cfg.cfg_period : tbl_period_r[0];

        case (state_r)
            ST_IDLE: begin
                tbl_we_s = cfg.cfg_we;
                if (start && !abort) begin
                    if (entry0_period_s != 16'd0) begin
                        state_s = ST_LOAD;
                        step_s  = 2'd0;
                        busy_s  = 1'b1;
                        len_s   = seq_len;
                        loop_s  = loop;
                    end else begin
                        cfg_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cfg_err_s = cfg.cfg_we;
                if (abort) begin
                    state_s  = ST_IDLE;
                    pwm_en_s = 1'b0;
                    busy_s   = 1'b0;
                end else begin
                    state_s   = ST_RUN;
                    period_s  = tbl_period_r[step];
                    dc_s      = tbl_dc_r[step];
                    rep_cnt_s = tbl_reps_r[step];
                    pwm_en_s  = 1'b1;
                end
            end
            ST_RUN: begin
                cfg_err_s = cfg.cfg_we;
                if (abort) begin
                    state_s  = ST_IDLE;
                    pwm_en_s = 1'b0;
                    busy_s   = 1'b0;
                end else if (period_tick) begin
                    if (rep_cnt_r != 8'd0) begin
                        rep_cnt_s = rep_cnt_r - 8'd1;
                    end else if ((step == len_r) && !loop_r) begin
                        state_s  = ST_DONE;
                        done_s   = 1'b1;
                        pwm_en_s = 1'b0;
                        busy_s   = 1'b0;
                    end else begin
                        step_s    = adv_step_s;
                        period_s  = tbl_period_r[adv_step_s];
                        dc_s      = tbl_dc_r[adv_step_s];
                        rep_cnt_s = tbl_reps_r[adv_step_s];
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                cfg_err_s = cfg.cfg_we;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                pwm_en_s = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            period_reg <= 16'd0;
            DC_reg     <= 16'd0;
            pwm_en     <= 1'b0;
            busy       <= 1'b0;
            step       <= 2'd0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            rep_cnt_r  <= 8'd0;
            len_r      <= 2'd0;
            loop_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            period_reg <= period_s;
            DC_reg     <= dc_s;
            pwm_en     <= pwm_en_s;
            busy       <= busy_s;
            step       <= step_s;
            done       <= done_s;
            cfg_err    <= cfg_err_s;
            rep_cnt_r  <= rep_cnt_s;
            len_r      <= len_s;
            loop_r     <= loop_s;
        end
    end

    // Step table storage; writable only while idle.
    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            tbl_period_r <= '{default: 16'd0};
            tbl_dc_r     <= '{default: 16'd0};
            tbl_reps_r   <= '{default: 8'd0};
        end else if (tbl_we_s) begin
            tbl_period_r[cfg.cfg_addr] <= cfg.cfg_period;
            tbl_dc_r[cfg.cfg_addr]     <= cfg.cfg_dc;
            tbl_reps_r[cfg.cfg_addr]   <= cfg.cfg_reps;
        end else begin
            tbl_period_r <= tbl_period_r;
            tbl_dc_r     <= tbl_dc_r;
            tbl_reps_r   <= tbl_reps_r;
        end
    end
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: directed vector table, hand-written corner sequences and
// random traffic compared against a segment-queue reference model.
module tb_pwm_seq_ctrl;
    logic        chosen_clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  seq_len = 2'd0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        period_tick = 1'b0;
    logic [15:0] period_reg, DC_reg;
    logic        pwm_en, busy, done, cfg_err;
    logic [1:0]  step;

    int n_err = 0;
    int n_chk = 0;

    pwm_seq_ctrl_if cfg_bus ();

    pwm_seq_ctrl dut (
        .chosen_clk (chosen_clk),
        .rst        (rst),
        .cfg        (cfg_bus),
        .seq_len    (seq_len),
        .loop       (loop),
        .start      (start),
        .abort      (abort),
        .period_tick(period_tick),
        .period_reg (period_reg),
        .DC_reg     (DC_reg),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .step       (step),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 chosen_clk = ~chosen_clk;

    // Reference model: a started sequence is a queue of PWM periods, one per tick.
    typedef struct {
        logic [1:0]  s;
        logic [15:0] p;
        logic [15:0] d;
    } seg_t;

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;

    seg_t        m_q[$];
    int          m_phase = PH_IDLE;
    logic [15:0] mt_p [4];
    logic [15:0] mt_d [4];
    logic [7:0]  mt_r [4];
    logic [15:0] m_per = 16'd0, m_dc = 16'd0;
    logic        m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_loop = 1'b0;
    logic [1:0]  m_step = 2'd0, m_len = 2'd0;

    task automatic build_queue();
        seg_t sg;
        m_q.delete();
        for (int s = 0; s <= int'(m_len); s++) begin
            for (int r = 0; r <= int'(mt_r[s]); r++) begin
                sg.s = 2'(s);
                sg.p = mt_p[s];
                sg.d = mt_d[s];
                m_q.push_back(sg);
            end
        end
    endtask

    task automatic take_seg();
        seg_t sg;
        sg = m_q.pop_front();
        m_step = sg.s;
        m_per  = sg.p;
        m_dc   = sg.d;
    endtask

    task automatic model_update();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_phase = PH_IDLE;
            m_per = 16'd0; m_dc = 16'd0; m_en = 1'b0; m_busy = 1'b0; m_step = 2'd0;
            m_q.delete();
            for (int i = 0; i < 4; i++) begin
                mt_p[i] = 16'd0; mt_d[i] = 16'd0; mt_r[i] = 8'd0;
            end
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (cfg_bus.cfg_we) begin
                        mt_p[cfg_bus.cfg_addr] = cfg_bus.cfg_period;
                        mt_d[cfg_bus.cfg_addr] = cfg_bus.cfg_dc;
                        mt_r[cfg_bus.cfg_addr] = cfg_bus.cfg_reps;
                    end
                    if (start && !abort) begin
                        if (mt_p[0] != 16'd0) begin
                            m_phase = PH_LOAD; m_busy = 1'b1; m_step = 2'd0;
                            m_len = seq_len; m_loop = loop;
                            build_queue();
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                PH_LOAD: begin
                    m_err = cfg_bus.cfg_we;
                    if (abort) begin
                        m_phase = PH_IDLE; m_busy = 1'b0; m_en = 1'b0;
                    end else begin
                        take_seg();
                        m_en = 1'b1;
                        m_phase = PH_RUN;
                    end
                end
                PH_RUN: begin
                    m_err = cfg_bus.cfg_we;
                    if (abort) begin
                        m_phase = PH_IDLE; m_busy = 1'b0; m_en = 1'b0;
                    end else if (period_tick) begin
                        if (m_q.size() != 0) begin
                            take_seg();
                        end else if (m_loop) begin
                            build_queue();
                            take_seg();
                        end else begin
                            m_phase = PH_DONE; m_done = 1'b1; m_en = 1'b0; m_busy = 1'b0;
                        end
                    end
                end
                default: begin
                    m_err = cfg_bus.cfg_we;
                    m_phase = PH_IDLE;
                end
            endcase
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge chosen_clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b0; start = 1'b0; abort = 1'b0; period_tick = 1'b0;
        cfg_bus.cfg_we = 1'b0;
    endtask

    task automatic set_wr(input logic [1:0] a, input logic [15:0] p, input logic [15:0] d,
                          input logic [7:0] r);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a;
        cfg_bus.cfg_period = p; cfg_bus.cfg_dc = d; cfg_bus.cfg_reps = r;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] p, input logic [15:0] d,
                      input logic [7:0] r);
        set_wr(a, p, d, r);
        cyc();
        clr();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ep, input logic [15:0] ed,
                             input logic een, input logic ebusy, input logic [1:0] estep,
                             input logic edone, input logic eerr);
        chk({tag, ".period_reg"}, period_reg, ep);
        chk({tag, ".DC_reg"},     DC_reg,     ed);
        chk({tag, ".pwm_en"},     {15'd0, pwm_en},  {15'd0, een});
        chk({tag, ".busy"},       {15'd0, busy},    {15'd0, ebusy});
        chk({tag, ".step"},       {14'd0, step},    {14'd0, estep});
        chk({tag, ".done"},       {15'd0, done},    {15'd0, edone});
        chk({tag, ".cfg_err"},    {15'd0, cfg_err}, {15'd0, eerr});
    endtask

    typedef struct {
        logic rst, we; logic [1:0] addr; logic [15:0] per, dc; logic [7:0] reps;
        logic [1:0] len; logic lp, st, ab, tk;
        logic [15:0] e_per, e_dc; logic e_en, e_busy; logic [1:0] e_step; logic e_done, e_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        clr();
        cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_period = 16'd0;
        cfg_bus.cfg_dc = 16'd0; cfg_bus.cfg_reps = 8'd0;

        // Reset, empty-table start, then the one-shot {6,3,0},{4,1,1} sequence.
        vecs[0]  = '{1'b1,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b0,2'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b1,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b0,2'd0,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b0,2'd0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,2'd0,16'd6,16'd3,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b0,2'd0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,2'd1,16'd4,16'd1,8'd1,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b0,2'd0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd1,1'b0,1'b1,1'b0,1'b0, 16'd0,16'd0,1'b0,1'b1,2'd0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd6,16'd3,1'b1,1'b1,2'd0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b1, 16'd4,16'd1,1'b1,1'b1,2'd1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd4,16'd1,1'b1,1'b1,2'd1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b1, 16'd4,16'd1,1'b1,1'b1,2'd1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b1, 16'd4,16'd1,1'b0,1'b0,2'd1,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b0,2'd0,16'd0,16'd0,8'd0,2'd0,1'b0,1'b0,1'b0,1'b0, 16'd4,16'd1,1'b0,1'b0,2'd1,1'b0,1'b0};

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            cfg_bus.cfg_we = vecs[i].we; cfg_bus.cfg_addr = vecs[i].addr;
            cfg_bus.cfg_period = vecs[i].per; cfg_bus.cfg_dc = vecs[i].dc;
            cfg_bus.cfg_reps = vecs[i].reps;
            seq_len = vecs[i].len; loop = vecs[i].lp;
            start = vecs[i].st; abort = vecs[i].ab; period_tick = vecs[i].tk;
            cyc();
            check_all($sformatf("vec%0d", i), vecs[i].e_per, vecs[i].e_dc, vecs[i].e_en,
                      vecs[i].e_busy, vecs[i].e_step, vecs[i].e_done, vecs[i].e_err);
        end
        clr();

        // Looping sequence with an unclamped duty cycle above the period.
        wr(2'd0, 16'd4, 16'd3, 8'd0);
        wr(2'd1, 16'd3, 16'd4, 8'd0);
        seq_len = 2'd1; loop = 1'b1; start = 1'b1; cyc(); clr();
        check_all("loop_load", 16'd4, 16'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc();
        check_all("loop_run", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        check_all("loop_t1", 16'd3, 16'd4, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        check_all("loop_wrap", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        abort = 1'b1; period_tick = 1'b1; cyc(); clr();
        check_all("abort_tick", 16'd3, 16'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        cyc();
        check_all("abort_after", 16'd3, 16'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

        // Write and start while busy are rejected / ignored.
        seq_len = 2'd1; loop = 1'b0; start = 1'b1; cyc(); clr();
        cyc();
        start = 1'b1; cyc(); clr();
        check_all("start_busy", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        set_wr(2'd0, 16'd9, 16'd9, 8'd0); cyc(); clr();
        check_all("busy_wr", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        cyc();
        check_all("busy_wr_after", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        abort = 1'b1; cyc(); clr();
        seq_len = 2'd0; start = 1'b1; cyc(); clr();
        cyc();
        check_all("restart", 16'd4, 16'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

        // Reset mid-run clears the table.
        rst = 1'b1; cyc(); clr();
        check_all("rst_run", 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        start = 1'b1; cyc(); clr();
        check_all("rst_start", 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

        // start+abort in idle; write+start in one cycle; tick ignored in LOAD.
        wr(2'd0, 16'd5, 16'd2, 8'd0);
        start = 1'b1; abort = 1'b1; cyc(); clr();
        check_all("start_abort", 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        set_wr(2'd0, 16'd7, 16'd2, 8'd0); seq_len = 2'd0; loop = 1'b0; start = 1'b1;
        cyc(); clr();
        check_all("wr_start_load", 16'd0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        check_all("wr_start_run", 16'd7, 16'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        check_all("oneshot_done", 16'd7, 16'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        period_tick = 1'b1; cyc(); clr();
        check_all("done_idle", 16'd7, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Random traffic against the reference model.
        rst = 1'b1; cyc(); clr();
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 49) == 0);
            period_tick = ($urandom_range(0, 2) == 0);
            seq_len     = 2'($urandom_range(0, 3));
            loop        = 1'($urandom_range(0, 1));
            cfg_bus.cfg_we     = ($urandom_range(0, 5) == 0);
            cfg_bus.cfg_addr   = 2'($urandom_range(0, 3));
            cfg_bus.cfg_period = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            cfg_bus.cfg_dc     = 16'($urandom_range(0, 65535));
            cfg_bus.cfg_reps   = 8'($urandom_range(0, 2));
            cyc();
            check_all("rnd", m_per, m_dc, m_en, m_busy, m_step, m_done, m_err);
        end
        clr();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have port: chosen_clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset, sampled on chosen_clk rising edge.
REQ-003 SHALL have port: cfg_we  in  1  table write strobe, one entry per asserted cycle.
REQ-004 SHALL have port: cfg_addr  in  2  table entry index 0..3.
REQ-005 SHALL have port: cfg_period  in  16  period value for the addressed entry.
REQ-006 SHALL have port: cfg_dc  in  16  duty-cycle value for the addressed entry.
REQ-007 SHALL have port: cfg_reps  in  8  extra repeats for the addressed entry; 0 means one PWM period.
REQ-008 SHALL have port: seq_len  in  2  last step index (number of steps minus 1).
REQ-009 SHALL have port: loop  in  1  1 = restart at step 0 after the last step; 0 = one-shot.
REQ-010 SHALL have port: start  in  1  single-cycle sequence start request.
REQ-011 SHALL have port: abort  in  1  single-cycle sequence stop request.
REQ-012 SHALL have port: period_tick  in  1  single-cycle pulse, one per completed PWM period, synchronous to chosen_clk.
REQ-013 SHALL have port: period_reg  out  16  period presented to the PWM datapath.
REQ-014 SHALL have port: DC_reg  out  16  duty cycle presented to the PWM datapath.
REQ-015 SHALL have port: pwm_en  out  1  PWM enable.
REQ-016 SHALL have port: busy  out  1  high in LOAD and RUN.
REQ-017 SHALL have port: step  out  2  index of the active table entry.
REQ-018 SHALL have port: done  out  1  one-cycle pulse when a one-shot sequence completes.
REQ-019 SHALL have port: cfg_err  out  1  one-cycle pulse on a rejected write or rejected start.

Function
REQ-020 SHALL hold a 4-entry table {period 16b, dc 16b, reps 8b}, written in IDLE on cfg_we at the next edge.
REQ-021 SHALL implement the FSM states IDLE, LOAD, RUN, DONE.
REQ-022 SHALL move IDLE->LOAD on start when entry 0 period != 0, latching seq_len and loop and setting step=0 and busy=1.
REQ-023 SHALL stay in IDLE and pulse cfg_err for one cycle on start when entry 0 period == 0.
REQ-024 SHALL, in LOAD (one cycle), copy table[step] to period_reg/DC_reg, load rep_cnt=reps, set pwm_en=1, and go to RUN.
REQ-025 SHALL, in RUN on period_tick with rep_cnt != 0, decrement rep_cnt and leave the outputs unchanged.
REQ-026 SHALL, in RUN on period_tick with rep_cnt == 0 and step < latched seq_len, increment step and load the new period_reg/DC_reg/rep_cnt on that same edge (visible in cycle N+1); no LOAD state.
REQ-027 SHALL, in RUN on period_tick with rep_cnt == 0 and step == seq_len and loop=1, wrap to step=0 and load entry 0 on that same edge.
REQ-028 SHALL, in RUN on period_tick with rep_cnt == 0 and step == seq_len and loop=0, go to DONE.
REQ-029 SHALL, in DONE (one cycle), assert done=1 and pwm_en=0 and busy=0, then go to IDLE; period_reg/DC_reg hold.
REQ-030 SHALL pass DC_reg through unmodified when dc > period (the datapath handles that case); no clamping.
REQ-031 SHALL skip a mid-sequence entry with period 0 (treated as a zero-length step); the sequencer advances on the next period_tick.
REQ-032 SHALL, on abort in LOAD or RUN, go to IDLE at the next edge with pwm_en=0 and busy=0, and no done pulse.
REQ-033 SHALL give abort priority over period_tick; abort and start together in IDLE leave the FSM in IDLE.
REQ-034 SHALL ignore start while busy.
REQ-035 SHALL ignore cfg_we while busy or in DONE, leave the table unchanged, and pulse cfg_err.
REQ-036 SHALL, when cfg_we and start occur in the same IDLE cycle, commit the write first, so LOAD sees the new value.
REQ-037 SHALL ignore period_tick in IDLE, LOAD and DONE.

Reset
REQ-038 SHALL, on rst, force state=IDLE, period_reg=0, DC_reg=0, pwm_en=0, busy=0, step=0, done=0, cfg_err=0, rep_cnt=0, all table entries=0.
REQ-039 SHALL give rst priority over all other inputs, including mid-sequence.

Verification
REQ-040 SHALL cover reset: rst asserted for 1 cycle -> all outputs 0; start with an empty table -> cfg_err pulse, busy=0.
REQ-041 SHALL cover one-shot: entries {6,3,0},{4,1,1}, seq_len=1, loop=0, start -> step 0 for 1 tick, step 1 for 2 ticks, then done pulse, pwm_en=0, period_reg=4, DC_reg=1.
REQ-042 SHALL cover loop: entries {4,3,0},{3,4,0}, seq_len=1, loop=1 -> after the 2nd tick, step=0 and period_reg=4, DC_reg=3; DC_reg=4 > period 3 is passed unclamped; no done pulse.
REQ-043 SHALL cover abort: abort and period_tick in the same RUN cycle -> next cycle IDLE, pwm_en=0, step unchanged, done=0.
REQ-044 SHALL cover busy write: cfg_we to addr 0 while RUN -> cfg_err pulse, table entry 0 unchanged (verified by a later restart).
REQ-045 SHALL cover rst mid-RUN: rst -> next cycle all reset values; a subsequent start -> cfg_err pulse (table cleared).
